// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between pipeline writeback and
// the multiply/divide unit (MDU). Pipeline writes win the port. MDU results
// wait in a small in-order FIFO and drain into free write slots. A full FIFO
// stalls the pipeline to force a drain. A pipeline write that overtakes a
// queued MDU result to the same register marks that entry killed, so it pops
// without writing.
//
// Optional build macro:
//   WB_ARB_STARVE_EN - adds a head-age counter. When the head has waited
//                      MAX_WAIT cycles, the block also stalls the pipeline so
//                      that the entry drains.
//
// Parameters:
//   DEPTH     FIFO entries, power of two, 2..8
//   MAX_WAIT  starvation limit in cycles, 1..15 (WB_ARB_STARVE_EN only)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   pipe_wen    pipeline writeback valid
//   pipe_rd     pipeline destination register
//   pipe_data   pipeline write data
//   mdu_valid   MDU result valid
//   mdu_rd      MDU destination register
//   mdu_data    MDU result
//   mdu_ready   FIFO can accept a result (not full)
//   rf_wen      register-file write enable (registered)
//   rf_rd       register-file write address (registered)
//   rf_data     register-file write data (registered)
//   stall       pipeline stall, decoded from registered state only
//   pend_count  FIFO occupancy

module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        stall,
  output logic [3:0]  pend_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       fifo_rd   [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_kill;
  logic [DEPTH-1:0] kill_next;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]    count;

  logic        full;
  logic        empty;
  logic        starving;
  logic        push;
  logic        pop;
  logic        pipe_go;
  logic        head_kill;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;

  assign full       = (count == 4'(DEPTH));
  assign empty      = (count == 4'd0);
  assign mdu_ready  = !full;
  assign pend_count = count;
  assign push       = mdu_valid && !full;
  assign head_kill  = fifo_kill[rd_ptr];
  assign stall      = full || starving;

`ifdef WB_ARB_STARVE_EN
  logic [3:0] age;

  assign starving = (age == 4'(MAX_WAIT)) && !empty;

  // Age of the current head; restarts whenever a new entry becomes head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      age <= 4'd0;
    end else if (pop || empty) begin
      age <= 4'd0;
    end else if (age != 4'(MAX_WAIT)) begin
      age <= age + 4'd1;
    end
  end
`else
  assign starving = 1'b0;
`endif

  // Port grant: forced drain while stalled, then pipeline, then FIFO.
  always_comb begin
    pop     = 1'b0;
    pipe_go = 1'b0;
    wr_en   = 1'b0;
    wr_rd   = fifo_rd[rd_ptr];
    wr_data = fifo_data[rd_ptr];
    if (stall) begin
      // stall implies a non-empty FIFO; pipe inputs are held upstream
      pop   = 1'b1;
      wr_en = !head_kill;
    end else if (pipe_wen && (pipe_rd != 5'd0)) begin
      pipe_go = 1'b1;
      wr_en   = 1'b1;
      wr_rd   = pipe_rd;
      wr_data = pipe_data;
      // a killed head needs no port slot, so it retires alongside
      pop     = !empty && head_kill;
    end else if (!empty) begin
      pop   = 1'b1;
      wr_en = !head_kill;
    end
  end

  // Kill bits. Free slots may pick up a stray kill here; that is harmless
  // because a push always rewrites the kill bit of the slot it fills.
  always_comb begin
    kill_next = fifo_kill;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_go && (fifo_rd[i] == pipe_rd)) begin
        kill_next[i] = 1'b1;
      end
    end
    if (push) begin
      kill_next[wr_ptr] = (mdu_rd == 5'd0) || (pipe_go && (mdu_rd == pipe_rd));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mdu_rd;
      fifo_data[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= 4'd0;
      fifo_kill <= '0;
      rf_wen    <= 1'b0;
      rf_rd     <= 5'd0;
      rf_data   <= 32'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count     <= count + {3'd0, push} - {3'd0, pop};
      fifo_kill <= kill_next;
      rf_wen    <= wr_en;
      if (wr_en) begin
        rf_rd   <= wr_rd;
        rf_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

`ifdef WB_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        stall;
  logic [3:0]  pend_count;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data),
    .stall(stall), .pend_count(pend_count)
  );

  // reference model: queue of pending MDU results in age order
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        kill;
  } ent_t;

  ent_t        q[$];
  int          age;
  logic        exp_wen;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        last_push;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_stall();
    return (q.size() == DEPTH) || (STARVE && (q.size() > 0) && (age == MAX_WAIT));
  endfunction

  task automatic model_step();
    logic stall_now, full_now, was_empty, popped, pipe_go, push;
    ent_t h;
    if (!rst) begin
      q.delete();
      age = 0;
      exp_wen = 1'b0; exp_rd = 5'd0; exp_data = 32'd0;
      last_push = 1'b0;
      return;
    end
    stall_now = m_stall();
    full_now  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    popped  = 1'b0;
    pipe_go = 1'b0;
    exp_wen = 1'b0;
    push    = mdu_valid && !full_now;
    if (stall_now) begin
      h = q.pop_front();
      popped = 1'b1;
      if (!h.kill) begin exp_wen = 1'b1; exp_rd = h.rd; exp_data = h.data; end
    end else if (pipe_wen && pipe_rd != 5'd0) begin
      pipe_go = 1'b1;
      exp_wen = 1'b1; exp_rd = pipe_rd; exp_data = pipe_data;
      if (q.size() > 0 && q[0].kill) begin
        void'(q.pop_front());
        popped = 1'b1;
      end
      foreach (q[i]) if (q[i].rd == pipe_rd) q[i].kill = 1'b1;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      popped = 1'b1;
      if (!h.kill) begin exp_wen = 1'b1; exp_rd = h.rd; exp_data = h.data; end
    end
    if (push) begin
      h.rd = mdu_rd; h.data = mdu_data;
      h.kill = (mdu_rd == 5'd0) || (pipe_go && mdu_rd == pipe_rd);
      q.push_back(h);
    end
    if (popped || was_empty) age = 0;
    else if (age < MAX_WAIT) age = age + 1;
    last_push = push;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("rf_wen", 32'(rf_wen), 32'(exp_wen));
    if (exp_wen) begin
      check_val("rf_rd", 32'(rf_rd), 32'(exp_rd));
      check_val("rf_data", rf_data, exp_data);
    end
    check_val("stall", 32'(stall), 32'(m_stall()));
    check_val("mdu_ready", 32'(mdu_ready), 32'(q.size() < DEPTH));
    check_val("pend_count", 32'(pend_count), 32'(q.size()));
  endtask

  task automatic rand_inputs(input int busy_pct, input int mdu_pct);
    if (!m_stall()) begin
      pipe_wen  = ($urandom_range(0, 99) < busy_pct);
      pipe_rd   = 5'($urandom_range(0, 7));
      pipe_data = $urandom;
    end
    if (!(mdu_valid && !last_push)) begin
      mdu_valid = ($urandom_range(0, 99) < mdu_pct);
      mdu_rd    = 5'($urandom_range(0, 7));
      mdu_data  = $urandom;
    end
  endtask

  task automatic idle_inputs();
    pipe_wen = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
  endtask

  initial begin
    int busy[4] = '{30, 70, 100, 90};
    idle_inputs();
    last_push = 1'b0;
    age = 0;

    // reset with random inputs
    rst = 1'b0;
    rand_inputs(50, 50);
    tick();
    rand_inputs(50, 50);
    tick();
    check_val("rst_rf_wen", 32'(rf_wen), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_mdu_ready", 32'(mdu_ready), 32'd1);
    check_val("rst_pend", 32'(pend_count), 32'd0);
    rst = 1'b1;
    idle_inputs();
    tick();

    // pipeline only
    pipe_wen = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h11;
    tick();
    check_val("pipe_wen", 32'(rf_wen), 32'd1);
    check_val("pipe_rd", 32'(rf_rd), 32'd5);
    check_val("pipe_data", rf_data, 32'h11);
    pipe_rd = 5'd0;
    tick();
    check_val("pipe_rd0", 32'(rf_wen), 32'd0);

    // MDU into idle port
    idle_inputs();
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'hAA;
    tick();
    mdu_valid = 1'b0;
    check_val("mdu_pend1", 32'(pend_count), 32'd1);
    tick();
    check_val("mdu_wen", 32'(rf_wen), 32'd1);
    check_val("mdu_rd", 32'(rf_rd), 32'd7);
    check_val("mdu_data", rf_data, 32'hAA);
    check_val("mdu_pend0", 32'(pend_count), 32'd0);

    // full drain: two pushes under continuous pipe writes
    pipe_wen = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h100;
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h77;
    tick();
    pipe_data = 32'h101; mdu_rd = 5'd8; mdu_data = 32'h88;
    tick();
    check_val("full_stall", 32'(stall), 32'd1);
    check_val("full_ready", 32'(mdu_ready), 32'd0);
    mdu_valid = 1'b0;
    pipe_data = 32'h102;
    tick();
    check_val("drain_rd", 32'(rf_rd), 32'd7);
    check_val("drain_stall", 32'(stall), 32'd0);
    tick();
    check_val("held_pipe", rf_data, 32'h102);
    pipe_wen = 1'b0;
    tick();
    check_val("drain2_rd", 32'(rf_rd), 32'd8);
    tick();

    // WAW kill
    idle_inputs();
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h1;
    tick();
    mdu_valid = 1'b0;
    pipe_wen = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h2;
    tick();
    check_val("waw_data", rf_data, 32'h2);
    pipe_wen = 1'b0;
    tick();
    check_val("waw_silent", 32'(rf_wen), 32'd0);
    check_val("waw_pend", 32'(pend_count), 32'd0);

    // one entry under continuous pipe writes
    pipe_wen = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h400;
    mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h66;
    tick();
    mdu_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (!m_stall()) pipe_data = pipe_data + 32'd1;
      tick();
    end
    pipe_wen = 1'b0;
    tick();
    tick();

    // randomized phases with a mid-run reset
    for (int p = 0; p < 4; p++) begin
      if (p == 2) begin
        rst = 1'b0;
        rand_inputs(50, 50);
        tick();
        tick();
        rst = 1'b1;
        idle_inputs();
      end
      for (int c = 0; c < 600; c++) begin
        rand_inputs(busy[p], 45);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
